// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered reads, write-first bypass,
// optional zero register 0 and a clear-on-reset init sequencer. Parity: define REGFILE_PARITY_EN.
module regfile_param #(
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int DEPTH   = 32,
  parameter int R0_ZERO = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] In,
  input  logic [AW-1:0] Writeaddress,
  input  logic          WE,
  input  logic [AW-1:0] Readaddress_A,
  input  logic          RE_A,
  input  logic [AW-1:0] Readaddress_B,
  input  logic          RE_B,
  input  logic          PINV,
  output logic [DW-1:0] outA,
  output logic [DW-1:0] outB,
  output logic          VALID_A,
  output logic          VALID_B,
  output logic          PERR_A,
  output logic          PERR_B,
  output logic          BUSY
);

`ifdef REGFILE_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  logic [MW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] wr_word;
  logic          run;

  // An address is "live" when it maps to real, writable storage.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((R0_ZERO != 0) && (a == '0));
  endfunction

`ifdef REGFILE_PARITY_EN
  assign wr_word = {(^In) ^ PINV, In};
`else
  logic unused_pinv;
  assign unused_pinv = PINV;
  assign wr_word     = In;
`endif

  assign run  = (state_reg == ST_RUN);
  assign BUSY = ~run;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_we     = 1'b0;
    mem_waddr  = Writeaddress;
    mem_wdata  = wr_word;
    case (state_reg)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
        if (cnt_reg == LAST) state_next = ST_RUN;
        else                 cnt_next   = cnt_reg + 1'b1;
      end
      ST_RUN: begin
        mem_we = WE && addr_live(Writeaddress);
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [AW-1:0] rd_addr [2];
  logic [1:0]    rd_en;

  assign rd_addr[0] = Readaddress_A;
  assign rd_addr[1] = Readaddress_B;
  assign rd_en      = {RE_B, RE_A};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic          live, hit, perr;
    logic [MW-1:0] word;
    logic [DW-1:0] data_reg;
    logic          valid_reg, perr_reg;

    assign live = addr_live(rd_addr[gi]);
    assign hit  = WE && (Writeaddress == rd_addr[gi]);
    assign word = mem[rd_addr[gi]];
`ifdef REGFILE_PARITY_EN
    // Only data actually coming out of storage can carry a parity fault.
    assign perr = live && !hit && (^word);
`else
    assign perr = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
        perr_reg  <= 1'b0;
      end else if (run && rd_en[gi]) begin
        data_reg  <= live ? (hit ? In : word[DW-1:0]) : '0;
        valid_reg <= 1'b1;
        perr_reg  <= perr;
      end else begin
        valid_reg <= 1'b0;
        perr_reg  <= 1'b0;
      end
    end
  end

  assign outA    = g_rd[0].data_reg;
  assign outB    = g_rd[1].data_reg;
  assign VALID_A = g_rd[0].valid_reg;
  assign VALID_B = g_rd[1].valid_reg;
  assign PERR_A  = g_rd[0].perr_reg;
  assign PERR_B  = g_rd[1].perr_reg;

endmodule
